// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: opcode encodings, IR field
// positions, fetch FSM states and the unused-encoding classifier.
package ifu_pkg;

   // Primary opcodes (IR[15:12]), same values the control FSM decodes
   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ANDI  = 4'h1;
   localparam logic [3:0] OP_ORI   = 4'h2;
   localparam logic [3:0] OP_XORI  = 4'h3;
   localparam logic [3:0] OP_MEM   = 4'h4;
   localparam logic [3:0] OP_ADDI  = 4'h5;
   localparam logic [3:0] OP_SHIFT = 4'h8;
   localparam logic [3:0] OP_SUBI  = 4'h9;
   localparam logic [3:0] OP_CMPI  = 4'hB;
   localparam logic [3:0] OP_BCOND = 4'hC;
   localparam logic [3:0] OP_MOVI  = 4'hD;
   localparam logic [3:0] OP_LUI   = 4'hF;

   // MEM sub-operations (IR[7:4] when opCode1 = OP_MEM)
   localparam logic [3:0] MEM_LB    = 4'h0;
   localparam logic [3:0] MEM_SB    = 4'h4;
   localparam logic [3:0] MEM_JAL   = 4'h8;
   localparam logic [3:0] MEM_JCOND = 4'hC;

   // SHIFT sub-operations (IR[7:4] when opCode1 = OP_SHIFT)
   localparam logic [3:0] SH_LSHI_L = 4'h0;
   localparam logic [3:0] SH_LSHI_R = 4'h1;
   localparam logic [3:0] SH_LSH    = 4'h4;
   localparam logic [3:0] SH_ASHU   = 4'h6;

   // IR field layout
   localparam int FIELD_W   = 4;
   localparam int IMM_W     = 8;
   localparam int OPC1_LSB  = 12;
   localparam int RDEST_LSB = 8;
   localparam int OPC2_LSB  = 4;
   localparam int RSRC_LSB  = 0;
   localparam int CNT_W     = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_CAPTURE = 2'd2
   } ifu_state_t;

   function automatic logic is_illegal_op(input logic [15:0] word);
      logic [3:0] opc1;
      logic [3:0] opc2;
      logic       bad;
      opc1 = word[OPC1_LSB +: FIELD_W];
      opc2 = word[OPC2_LSB +: FIELD_W];
      bad  = 1'b0;
      case (opc1)
         4'h6, 4'h7, 4'hA, 4'hE: bad = 1'b1;
         OP_MEM:   bad = !(opc2 == MEM_LB || opc2 == MEM_SB ||
                           opc2 == MEM_JAL || opc2 == MEM_JCOND);
         OP_SHIFT: bad = !(opc2 == SH_LSHI_L || opc2 == SH_LSHI_R ||
                           opc2 == SH_LSH || opc2 == SH_ASHU);
         default:  bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port between the fetch unit (master) and the shared
// memory (slave).
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_rd_en,
      output mem_addr,
      input  mem_rdata
   );

   modport slave (
      input  mem_rd_en,
      input  mem_addr,
      output mem_rdata
   );
endinterface

// File: rtl/ifu_pc_next.sv
// Combinational next-PC selection: jump/JAL target, IR-relative branch, or
// sequential increment. All arithmetic wraps modulo 2^ADDR_W.
module ifu_pc_next #(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] ir_pc,
   input  logic [ADDR_W-1:0] jmp_target,
   input  logic [7:0]        imm8,
   input  logic              branch_en,
   input  logic              jmp_en,
   input  logic              jal_en,
   output logic [ADDR_W-1:0] pc_next
);

   logic [ADDR_W-1:0] imm_sext;

   assign imm_sext = {{(ADDR_W-8){imm8[7]}}, imm8};

   // Jumps outrank branches, which outrank the plain increment
   always_comb begin
      pc_next = pc + ADDR_W'(1);
      if (jmp_en || jal_en) begin
         pc_next = jmp_target;
      end else if (branch_en) begin
         pc_next = ir_pc + imm_sext;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one memory read per fetch request,
// captures the word into the IR and splits it into decode fields.
// Optional macro IFU_ILLEGAL_OP_DETECT_EN adds a sticky illegal_op output.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 16,
   parameter int                MEM_LAT  = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_start,
   input  logic              pc_en,
   input  logic              branch_en,
   input  logic              jmp_en,
   input  logic              jal_en,
   input  logic [ADDR_W-1:0] jmp_target,
   instr_fetch_unit_if.master mem,
   output logic              busy,
   output logic              instr_valid,
   output logic [3:0]        opCode1,
   output logic [3:0]        rdest,
   output logic [3:0]        opCode2,
   output logic [3:0]        rsrc,
   output logic [7:0]        imm8,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] link_addr
`ifdef IFU_ILLEGAL_OP_DETECT_EN
   ,
   output logic              illegal_op
`endif
);

   ifu_state_t        state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [ADDR_W-1:0] fetch_pc_reg;
   logic [ADDR_W-1:0] ir_pc_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] ir_reg;
   logic              rd_en_reg;
   logic              busy_reg;
   logic              valid_reg;
   logic              start_fetch;
   logic              do_capture;

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      start_fetch = 1'b0;
      do_capture  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (fetch_start) begin
               start_fetch = 1'b1;
               cnt_next    = CNT_W'(MEM_LAT - 1);
               state_next  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_reg == '0) begin
               state_next = ST_CAPTURE;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         ST_CAPTURE: begin
            do_capture = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Read data is valid in the CAPTURE cycle, so the IR updates on its closing edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         rd_en_reg    <= 1'b0;
         busy_reg     <= 1'b0;
         valid_reg    <= 1'b0;
         addr_reg     <= '0;
         fetch_pc_reg <= '0;
         ir_reg       <= '0;
         ir_pc_reg    <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         rd_en_reg <= start_fetch;
         busy_reg  <= (state_next != ST_IDLE);
         valid_reg <= (state_next == ST_CAPTURE);
         if (start_fetch) begin
            addr_reg     <= pc_reg;
            fetch_pc_reg <= pc_reg;
         end
         if (do_capture) begin
            ir_reg    <= mem.mem_rdata;
            ir_pc_reg <= fetch_pc_reg;
         end
      end
   end

   // The PC is independent of the fetch FSM; an in-flight read keeps its own address
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg <= RESET_PC;
      end else if (pc_en) begin
         pc_reg <= pc_next;
      end
   end

   ifu_pc_next #(
      .ADDR_W (ADDR_W)
   ) u_pc_next (
      .pc         (pc_reg),
      .ir_pc      (ir_pc_reg),
      .jmp_target (jmp_target),
      .imm8       (imm8),
      .branch_en  (branch_en),
      .jmp_en     (jmp_en),
      .jal_en     (jal_en),
      .pc_next    (pc_next)
   );

`ifdef IFU_ILLEGAL_OP_DETECT_EN
   logic illegal_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         illegal_reg <= 1'b0;
      end else if (do_capture && is_illegal_op(mem.mem_rdata[15:0])) begin
         illegal_reg <= 1'b1;
      end
   end

   assign illegal_op = illegal_reg;
`endif

   assign mem.mem_rd_en = rd_en_reg;
   assign mem.mem_addr  = addr_reg;
   assign busy          = busy_reg;
   assign instr_valid   = valid_reg;
   assign opCode1       = ir_reg[OPC1_LSB +: FIELD_W];
   assign rdest         = ir_reg[RDEST_LSB +: FIELD_W];
   assign opCode2       = ir_reg[OPC2_LSB +: FIELD_W];
   assign rsrc          = ir_reg[RSRC_LSB +: FIELD_W];
   assign imm8          = ir_reg[IMM_W-1:0];
   assign pc_out        = pc_reg;
   assign link_addr     = ir_pc_reg + ADDR_W'(1);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the control FSM. It owns the program counter (PC), issues instruction reads to the shared memory, and captures the returned word into an instruction register (IR).
- It splits the IR into the fields the control FSM consumes: opCode1, opCode2, conditionCode/Rdest, and shiftAmt/Rsrc.
- It applies the control FSM's PC-update strobes: sequential increment, conditional branch, jump, and JAL with link-address generation.

Parameters:
- ADDR_W, 16, PC and memory address width.
- DATA_W, 16, instruction word width; fixed field layout requires 16.
- MEM_LAT, 2, memory read latency in cycles, from rd_en to valid rdata; legal range 1..7.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_start  in  1  pulse from the control FSM (nextInstruction) requesting a fetch at the current PC.
- pc_en  in  1  PC write enable from the control FSM (PCEN).
- branch_en  in  1  take relative branch (BranchEN).
- jmp_en  in  1  take register jump (JmpEN).
- jal_en  in  1  take jump-and-link (JALEN).
- jmp_target  in  ADDR_W  register value for jump/JAL.
- mem_rdata  in  DATA_W  memory read data.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- busy  out  1  fetch in progress.
- instr_valid  out  1  one-cycle pulse when a new IR word is captured.
- opCode1  out  4  IR[15:12].
- rdest  out  4  IR[11:8]; this is also the conditionCode field.
- opCode2  out  4  IR[7:4].
- rsrc  out  4  IR[3:0]; this is also the shift-amount field.
- imm8  out  8  IR[7:0].
- pc_out  out  ADDR_W  current PC.
- link_addr  out  ADDR_W  ir_pc + 1, used as the JAL write-back value.

Behaviour:
- Reset (async, active-low): the following reset values apply.
  - pc = RESET_PC; ir = 0; ir_pc = 0.
  - state = IDLE; wait counter = 0.
  - mem_rd_en = 0; busy = 0; instr_valid = 0; mem_addr = 0.
- The field outputs are combinational from the IR, so all fields read 0 during reset.
- FSM states: IDLE, WAIT, CAPTURE.
  - IDLE: on fetch_start, register mem_addr = pc and ir_pc_next = pc, assert mem_rd_en for exactly one cycle, load counter = MEM_LAT-1, and go to WAIT. busy rises on the same edge.
  - WAIT: decrement the counter each cycle; go to CAPTURE when the counter reaches 0. With MEM_LAT=1, go to CAPTURE directly.
  - CAPTURE: ir <= mem_rdata; ir_pc <= ir_pc_next; pulse instr_valid for one cycle; busy drops; return to IDLE.
  - Latency: fetch_start in cycle N gives instr_valid in cycle N+MEM_LAT+1.
- fetch_start while busy is ignored; no queueing and no error.
- PC update happens only on a cycle with pc_en=1. Priority order:
  1. (jmp_en | jal_en): pc <= jmp_target.
  2. else branch_en: pc <= ir_pc + sign_extend(imm8).
  3. else: pc <= pc + 1.
- Arithmetic is modulo 2^ADDR_W; wrap-around is silent (0xFFFF + 1 = 0x0000).
- fetch_start and pc_en in the same cycle: the fetch uses the pre-update PC and the PC increments. This matches the FSM's FETCH state.
- pc_en during WAIT or CAPTURE is allowed and does not disturb the in-flight fetch.
- Relative to the IR:
  - ir_pc holds the address of the instruction currently in the IR.
  - link_addr = ir_pc + 1, combinational.
  - The IR holds its value until the next CAPTURE.
- Reset asserted mid-fetch: the in-flight read is abandoned and mem_rdata is ignored after reset release.

Optional Feature:
- Macro: IFU_ILLEGAL_OP_DETECT_EN.
- When defined:
  - Add an output illegal_op (1 bit, registered, sticky).
  - It sets on CAPTURE when the word decodes to an unused encoding: opCode1 ∈ {0x6, 0x7, 0xA, 0xE}; or opCode1=0x4 with opCode2 ∉ {0x0, 0x4, 0x8, 0xC}; or opCode1=0x8 with opCode2 ∉ {0x0, 0x1, 0x4, 0x6}.
  - It clears only on reset. A second illegal capture holds 1.
- When undefined: no port and no logic. All other behaviour is identical.

Decomposition:
- Shared package ifu_pkg holds:
  - the opcode localparams (RTYPE, MEM, SHIFT, BCOND, LUI, ADDI…) and the MEM sub-op codes (LB, SB, JAL, JCOND), which are the same values the control FSM decodes;
  - the field bit positions;
  - the IFU state enum.
- One natural sub-module: ifu_pc_next, the combinational next-PC mux and adder (increment, sign-extended branch add, jump select). The FSM, counter and IR stay in the top module.

Test Plan:
- Reset, then fetch_start with mem_rdata=0x5312 and MEM_LAT=2 -> mem_rd_en at N+1, mem_addr=0x0000, instr_valid at N+3; opCode1=5, rdest=3, opCode2=1, rsrc=2, imm8=0x12.
- fetch_start with pc_en together at pc=0x0010 -> mem_addr=0x0010, pc=0x0011, link_addr=0x0011 after capture.
- ir_pc=0x0020 with imm8=0xFE, then pc_en with branch_en -> pc=0x001E. With imm8=0x05 -> pc=0x0025.
- pc_en with jal_en, branch_en and jmp_target=0x1234 all asserted -> pc=0x1234, since the jump wins. pc=0xFFFF with pc_en alone -> pc=0x0000.
- fetch_start pulses during WAIT -> only one mem_rd_en. Reset asserted mid-WAIT -> busy=0, instr_valid never pulses, IR=0.
- With IFU_ILLEGAL_OP_DETECT_EN, capture 0x6000 -> illegal_op=1; it stays 1 after a later 0x5312 capture and clears only on reset.
